// File: rtl/led_scanner_pkg.sv
// Shared definitions for the LED scanner: scan modes, direction codes and
// the board-level one-second period constant for a 125 MHz clock.
package led_scanner_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'd0,
        MODE_WRAP_UP = 2'd1,
        MODE_WRAP_DN = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // period_i value giving one tick per second at 125 MHz
    localparam logic [31:0] ONE_SEC_125M = 32'd124_999_999;

endpackage

// File: rtl/led_scanner_tick_div.sv
// Programmable tick divider: emits a one-cycle tick every period_i+1 enabled
// cycles. The count freezes while en_i is low; shrinking period_i below the
// current count yields a tick on the very next cycle.
module tick_div
    import led_scanner_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             tick_s;

    // Next count and tick decision for the current cycle
    always_comb begin
        cnt_d  = cnt_q;
        tick_s = 1'b0;
        if (en_i) begin
            if (cnt_q >= period_i) begin
                cnt_d  = {DIV_W{1'b0}};
                tick_s = 1'b1;
            end else begin
                cnt_d  = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
                tick_s = 1'b0;
            end
        end else begin
            cnt_d  = cnt_q;
            tick_s = 1'b0;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = tick_s;

endmodule

// File: rtl/led_scanner.sv
// Parametrised scanning-light driver for board LED pins. A one-hot head steps
// once per divider tick in bounce, wrap-up or wrap-down fashion, or holds.
// Optional build macro LED_SCANNER_TRAIL_EN adds a tail LED at the position
// the head just left.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int LED_W = 8,
    parameter int DIV_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [DIV_W-1:0] period_i,
    output logic [LED_W-1:0] led_o,
    output logic             dir_o,
    output logic             end_o
);

    localparam int POS_W = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(LED_W - 1);

    logic             tick_s;
    mode_e            mode_s;

    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic             dir_q;
    logic             dir_d;
    logic             end_q;
    logic             end_d;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] led_d;
`ifdef LED_SCANNER_TRAIL_EN
    logic [POS_W-1:0] tpos_q;
    logic [POS_W-1:0] tpos_d;
`endif

    tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .period_i (period_i),
        .tick_o   (tick_s)
    );

    assign mode_s = mode_e'(mode_i);

    // Step FSM: next head position, direction and end-pulse on a tick
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        end_d = 1'b0;
        if (tick_s) begin
            case (mode_s)
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (pos_q == POS_MAX) begin
                            pos_d = POS_MAX - POS_ONE;
                            dir_d = DIR_DN;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end else begin
                        if (pos_q == POS_ZERO) begin
                            pos_d = POS_ONE;
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                    end_d = (pos_d == POS_ZERO) || (pos_d == POS_MAX);
                end
                MODE_WRAP_UP: begin
                    if (pos_q == POS_MAX) begin
                        pos_d = POS_ZERO;
                    end else begin
                        pos_d = pos_q + POS_ONE;
                    end
                    dir_d = DIR_UP;
                    end_d = (pos_d == POS_ZERO);
                end
                MODE_WRAP_DN: begin
                    if (pos_q == POS_ZERO) begin
                        pos_d = POS_MAX;
                    end else begin
                        pos_d = pos_q - POS_ONE;
                    end
                    dir_d = DIR_DN;
                    end_d = (pos_d == POS_MAX);
                end
                MODE_HOLD: begin
                    pos_d = pos_q;
                    dir_d = dir_q;
                    end_d = 1'b0;
                end
                default: begin
                    pos_d = pos_q;
                    dir_d = dir_q;
                    end_d = 1'b0;
                end
            endcase
        end else begin
            pos_d = pos_q;
            dir_d = dir_q;
            end_d = 1'b0;
        end
    end

`ifdef LED_SCANNER_TRAIL_EN
    // Tail follows the head: every real step moves pos, so a change marks a step
    always_comb begin
        if (pos_d != pos_q) begin
            tpos_d = pos_q;
        end else begin
            tpos_d = tpos_q;
        end
    end
`endif

    // LED pattern decoded from the next head (and tail) position
    always_comb begin
        led_d = {LED_W{1'b0}};
        for (int i = 0; i < LED_W; i++) begin
`ifdef LED_SCANNER_TRAIL_EN
            led_d[i] = (pos_d == POS_W'(i)) || (tpos_d == POS_W'(i));
`else
            led_d[i] = (pos_d == POS_W'(i));
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos_q  <= POS_ZERO;
            dir_q  <= DIR_UP;
            end_q  <= 1'b0;
            led_q  <= {{(LED_W-1){1'b0}}, 1'b1};
`ifdef LED_SCANNER_TRAIL_EN
            tpos_q <= POS_ZERO;
`endif
        end else begin
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            end_q  <= end_d;
            led_q  <= led_d;
`ifdef LED_SCANNER_TRAIL_EN
            tpos_q <= tpos_d;
`endif
        end
    end

    assign led_o = led_q;
    assign dir_o = dir_q;
    assign end_o = end_q;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: a 4-LED instance for bounce, async reset,
// hold and wrap-down; a 5-LED instance for wrap, enable freeze and period change.
module tb_led_scanner;

`ifdef LED_SCANNER_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic        clk;
    logic        rst4, en4, dir4, end4;
    logic [1:0]  mode4;
    logic [31:0] per4;
    logic [3:0]  led4;
    logic        rst5, en5, dir5, end5;
    logic [1:0]  mode5;
    logic [31:0] per5;
    logic [4:0]  led5;

    int checks = 0;
    int errors = 0;

    // expected 5-LED state tracked by the bench
    int exp_p5 = 0;
    int exp_t5 = 0;

    int p4 [10] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
    int d4 [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    int e4 [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};

    led_scanner #(.LED_W(4), .DIV_W(32)) u4 (
        .clk_i(clk), .rst_i(rst4), .en_i(en4), .mode_i(mode4),
        .period_i(per4), .led_o(led4), .dir_o(dir4), .end_o(end4)
    );

    led_scanner #(.LED_W(5), .DIV_W(32)) u5 (
        .clk_i(clk), .rst_i(rst5), .en_i(en5), .mode_i(mode5),
        .period_i(per5), .led_o(led5), .dir_o(dir5), .end_o(end5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_led4(input int p, input int t);
        logic [3:0] v;
        v = 4'b0000;
        v[p] = 1'b1;
        if (TRAIL) v[t] = 1'b1;
        return v;
    endfunction

    function automatic logic [4:0] exp_led5(input int p, input int t);
        logic [4:0] v;
        v = 5'b00000;
        v[p] = 1'b1;
        if (TRAIL) v[t] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Wait 'cycles' negedges on the 5-LED unit; head must stay put until the last one
    task automatic step5(input string tag, input int cycles, input int np, input int nd, input int ne);
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (c < cycles) begin
                chk({tag, "_wait_led"}, 32'(led5), 32'(exp_led5(exp_p5, exp_t5)));
                chk({tag, "_wait_end"}, 32'(end5), 32'd0);
            end else begin
                exp_t5 = exp_p5;
                exp_p5 = np;
                chk({tag, "_led"}, 32'(led5), 32'(exp_led5(exp_p5, exp_t5)));
                chk({tag, "_dir"}, 32'(dir5), 32'(nd));
                chk({tag, "_end"}, 32'(end5), 32'(ne));
            end
        end
    endtask

    initial begin
        int prev;
        rst4 = 1'b0; en4 = 1'b1; mode4 = 2'd0; per4 = 32'd0;
        rst5 = 1'b0; en5 = 1'b1; mode5 = 2'd1; per5 = 32'd2;
        #1;
        rst4 = 1'b1; rst5 = 1'b1;
        #1;
        chk("rst_led4", 32'(led4), 32'h1);
        chk("rst_dir4", 32'(dir4), 32'd0);
        chk("rst_end4", 32'(end4), 32'd0);
        chk("rst_led5", 32'(led5), 32'h1);

        // bounce, period 0, LED_W=4
        @(negedge clk);
        rst4 = 1'b0;
        chk("bounce_init_led", 32'(led4), 32'h1);
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bounce_led", 32'(led4), 32'(exp_led4(p4[k], prev)));
            chk("bounce_dir", 32'(dir4), 32'(d4[k]));
            chk("bounce_end", 32'(end4), 32'(e4[k]));
            prev = p4[k];
        end

        // async reset mid-bounce (pos=2, dir=1), observed before the next edge
        #2;
        rst4 = 1'b1;
        #1;
        chk("async_rst_led", 32'(led4), 32'h1);
        chk("async_rst_dir", 32'(dir4), 32'd0);
        chk("async_rst_end", 32'(end4), 32'd0);

        // hold: ticks every cycle, nothing moves
        @(negedge clk);
        mode4 = 2'd3;
        rst4 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("hold_led", 32'(led4), 32'h1);
            chk("hold_end", 32'(end4), 32'd0);
        end

        // wrap-down from 0 wraps to LED_W-1 with an end pulse
        mode4 = 2'd2;
        @(negedge clk);
        chk("wdn4_led", 32'(led4), 32'(exp_led4(3, 0)));
        chk("wdn4_dir", 32'(dir4), 32'd1);
        chk("wdn4_end", 32'(end4), 32'd1);
        @(negedge clk);
        chk("wdn4_led2", 32'(led4), 32'(exp_led4(2, 3)));
        chk("wdn4_end2", 32'(end4), 32'd0);

        // LED_W=5 wrap-up, period 2, then wrap-down
        @(negedge clk);
        rst5 = 1'b0;
        exp_p5 = 0; exp_t5 = 0;
        step5("wup1", 3, 1, 0, 0);
        step5("wup2", 3, 2, 0, 0);
        step5("wup3", 3, 3, 0, 0);
        step5("wup4", 3, 4, 0, 0);
        step5("wup0", 3, 0, 0, 1);
        mode5 = 2'd2;
        step5("wdn4", 3, 4, 1, 1);
        step5("wdn3", 3, 3, 1, 0);
        step5("wdn2", 3, 2, 1, 0);

        // enable freeze: period 9, drop en at cnt=5 for 20 cycles
        #2;
        rst5 = 1'b1;
        @(negedge clk);
        rst5 = 1'b0; mode5 = 2'd1; per5 = 32'd9; en5 = 1'b1;
        exp_p5 = 0; exp_t5 = 0;
        repeat (5) @(negedge clk);
        en5 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("frz_led", 32'(led5), 32'(exp_led5(0, 0)));
            chk("frz_end", 32'(end5), 32'd0);
        end
        en5 = 1'b1;
        step5("reen1", 5, 1, 0, 0);
        step5("reen2", 10, 2, 0, 0);

        // period shrink: 100 -> 10 with cnt at 50
        #2;
        rst5 = 1'b1;
        @(negedge clk);
        rst5 = 1'b0; per5 = 32'd100;
        exp_p5 = 0; exp_t5 = 0;
        repeat (50) @(negedge clk);
        chk("shr_led_pre", 32'(led5), 32'(exp_led5(0, 0)));
        per5 = 32'd10;
        step5("shr1", 1, 1, 0, 0);
        step5("shr2", 11, 2, 0, 0);
        step5("shr3", 11, 3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
